// File: rtl/sdrc_wb_traffic_master_if.sv
// Wishbone bus between the traffic master and an SDRAM-controller slave port.
interface sdrc_wb_traffic_master_if #(
    parameter int APP_AW = 26,
    parameter int DW     = 32
);
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [APP_AW-1:0] wb_addr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic              wb_ack_i;
    logic [DW-1:0]     wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/sdrc_wb_traffic_master.sv
// Self-checking Wishbone burst initiator: writes a seed+k pattern, or reads it
// back and counts beats that differ from the pattern.
module sdrc_wb_traffic_master #(
    parameter int APP_AW  = 26,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              sys_clk,
    input  logic              RESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [DW-1:0]     cmd_seed,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [15:0]       err_cnt,
    input  logic              clr_err,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    sdrc_wb_traffic_master_if.master wb
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int BW = DW / 8;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [APP_AW-1:0] ALIGN_MASK = ~APP_AW'(BW - 1);

    logic [1:0]        state;
    logic              we_r;
    logic [APP_AW-1:0] addr_r;
    logic [7:0]        len_r;
    logic [DW-1:0]     seed_r;
    logic [7:0]        beat;
    logic [TW-1:0]     tcnt;

    logic              accept;
    logic              in_bus;
    logic              ack;
    logic              last_beat;
    logic              tmo;
    logic [DW-1:0]     pattern;

    assign accept    = cmd_valid & cmd_ready;
    assign in_bus    = (state == S_BUS);
    assign ack       = in_bus & wb.wb_ack_i;
    assign last_beat = (beat == len_r - 8'd1);
    assign tmo       = in_bus & ~wb.wb_ack_i & (tcnt == TW'(TIMEOUT));
    assign pattern   = seed_r + DW'(beat);

    assign cmd_ready = (state == S_IDLE);
    assign busy      = in_bus;
    assign done      = (state == S_DONE);

    // Bus outputs are decoded from state so an async reset drops them at once
    assign wb.wb_cyc_o  = in_bus;
    assign wb.wb_stb_o  = in_bus;
    assign wb.wb_we_o   = in_bus & we_r;
    assign wb.wb_addr_o = in_bus ? addr_r : '0;
    assign wb.wb_dat_o  = (in_bus & we_r) ? pattern : '0;
    assign wb.wb_sel_o  = in_bus ? '1 : '0;
    assign wb.wb_cti_o  = in_bus ? (last_beat ? 3'b111 : 3'b010) : 3'b000;

    // Command FSM: latch command, step beats on ack, abort on timeout
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state  <= S_IDLE;
            we_r   <= 1'b0;
            addr_r <= '0;
            len_r  <= '0;
            seed_r <= '0;
            beat   <= '0;
            tcnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_r   <= cmd_we;
                        addr_r <= cmd_addr & ALIGN_MASK;
                        len_r  <= cmd_len;
                        seed_r <= cmd_seed;
                        beat   <= '0;
                        tcnt   <= '0;
                        state  <= (cmd_len == 8'd0) ? S_DONE : S_BUS;
                    end
                end
                S_BUS: begin
                    if (ack) begin
                        tcnt <= '0;
                        if (last_beat) begin
                            state <= S_DONE;
                        end else begin
                            beat   <= beat + 8'd1;
                            addr_r <= addr_r + APP_AW'(BW);
                        end
                    end else if (tmo) begin
                        state <= S_DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read capture, mismatch counting and sticky timeout flag; clear has priority
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            err_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            rd_valid <= ack & ~we_r;
            if (ack & ~we_r) begin
                rd_data <= wb.wb_dat_i;
            end
            if (clr_err) begin
                err_cnt <= '0;
            end else if (ack & ~we_r & (wb.wb_dat_i != pattern) & (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
            if (clr_err) begin
                timeout_err <= 1'b0;
            end else if (tmo) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
